// File: rtl/comp_two_arbiter.sv
// Round-robin arbiter sharing one external two's-complement negation unit between two requesters.
// Optional COMP_TWO_OVF_EN adds the OVF flag (operand was the most negative value).
module comp_two_arbiter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             REQ0,
    input  logic             REQ1,
    input  logic [WIDTH-1:0] DIN0,
    input  logic [WIDTH-1:0] DIN1,
    output logic [WIDTH-1:0] NEG_IN,
    input  logic [WIDTH-1:0] NEG_OUT,
    output logic             GNT0,
    output logic             GNT1,
    output logic             DONE0,
    output logic             DONE1,
    output logic [WIDTH-1:0] DOUT,
    output logic             BUSY
`ifdef COMP_TWO_OVF_EN
    ,
    output logic             OVF
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_CAPTURE,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic             last_q, last_d;
    logic [WIDTH-1:0] opr_q, opr_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             gnt0_q, gnt0_d;
    logic             gnt1_q, gnt1_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             pick0;
`ifdef COMP_TWO_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // On a tie the requester that did not win last time takes the unit.
    assign pick0 = REQ0 && (!REQ1 || last_q);

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        opr_d   = opr_q;
        dout_d  = dout_q;
        gnt0_d  = gnt0_q;
        gnt1_d  = gnt1_q;
        done0_d = done0_q;
        done1_d = done1_q;
`ifdef COMP_TWO_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    opr_d   = pick0 ? DIN0 : DIN1;
                    gnt0_d  = pick0;
                    gnt1_d  = !pick0;
                    last_d  = !pick0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_CAPTURE;
            end
            S_CAPTURE: begin
                dout_d  = NEG_OUT;
                done0_d = gnt0_q;
                done1_d = gnt1_q;
`ifdef COMP_TWO_OVF_EN
                ovf_d   = (opr_q == {1'b1, {(WIDTH-1){1'b0}}});
`endif
                state_d = S_RESP;
            end
            S_RESP: begin
                done0_d = 1'b0;
                done1_d = 1'b0;
                gnt0_d  = 1'b0;
                gnt1_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            opr_q   <= '0;
            dout_q  <= '0;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
`ifdef COMP_TWO_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            opr_q   <= opr_d;
            dout_q  <= dout_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
`ifdef COMP_TWO_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign NEG_IN = opr_q;
    assign GNT0   = gnt0_q;
    assign GNT1   = gnt1_q;
    assign DONE0  = done0_q;
    assign DONE1  = done1_q;
    assign DOUT   = dout_q;
    assign BUSY   = (state_q != S_IDLE);
`ifdef COMP_TWO_OVF_EN
    assign OVF    = ovf_q;
`endif

endmodule

// File: doc/comp_two_arbiter.md
# comp_two_arbiter

Shares one two's-complement (negation) unit between two requesters, for example the ALU SUB path and the immediate-negate path of the lab processor. The block arbitrates round-robin, latches the winning operand, drives the shared unit, waits one cycle for its result, and returns the result with a one-cycle completion pulse. It sits between the requesters and the single negation unit, so only one unit is instantiated per datapath.

## Interface
- WIDTH, 8, operand/result width in bits.

- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- REQ0, REQ1  in  1  request, held high until the matching DONE is seen.
- DIN0, DIN1  in  WIDTH  operand; must be valid while REQx is high and IDLE is sampling.
- NEG_IN  out  WIDTH  operand driven to the shared negation unit.
- NEG_OUT  in  WIDTH  result returned from the shared unit; it must be settled one cycle after NEG_IN changes.
- GNT0, GNT1  out  1  the requester currently owning the unit.
- DONE0, DONE1  out  1  one-cycle pulse; DOUT is valid for the granted requester.
- DOUT  out  WIDTH  registered result, held until the next capture.
- BUSY  out  1  high whenever state is not IDLE.
- OVF  out  1  present only with COMP_TWO_OVF_EN (see Configuration).

## Operation
- The FSM has four states: IDLE, ISSUE, CAPTURE and RESP.
- **IDLE:**
  - No REQ high: stay in IDLE.
  - Any REQ high: grant a requester, set OPR and NEG_IN to its DINx, set GNTx, record the winner in LAST, and go to ISSUE.
- **Arbitration:**
  - One requester high: that requester wins.
  - Both high: the requester that is not LAST wins.
  - LAST resets to 1, so requester 0 wins the first tie.
- **ISSUE:** hold NEG_IN, go to CAPTURE. This gives the unit one full cycle.
- **CAPTURE:** set DOUT to NEG_OUT, assert DONEx for the granted requester, go to RESP.
- **RESP:** clear DONEx and GNTx, go to IDLE.
  - REQ inputs are ignored in this state.
  - A REQ still high at the next IDLE sample counts as a new request.
- The operand is latched at grant. Changes to DINx after the grant have no effect.
- **Arithmetic:** DOUT equals (~OPR + 1) mod 2^WIDTH, as computed by the external unit. The block does no arithmetic of its own on the data path.
  - Operand 0 gives 0.
  - Operand 100..0 (the most negative value) gives itself.
- **RESET (any state, including mid-operation):**
  - State goes to IDLE and the in-flight operation is dropped.
  - No DONE is issued for the dropped operation.
  - All outputs go to their reset values.
- **Reset values:** NEG_IN=0, DOUT=0, GNT0/1=0, DONE0/1=0, BUSY=0, OVF=0, LAST=1.

## Timing
- Request sampled at edge t0 (state IDLE): GNT and NEG_IN update after t0.
- Edge t1: state goes from ISSUE to CAPTURE.
- Edge t2: DOUT and DONEx update.
- DONEx is high for the cycle between edges t2 and t3.
- Edge t3: state returns to IDLE, and GNTx and BUSY drop.
- Earliest next grant is edge t4, so throughput is one operation per 4 cycles.
- Latency from request sample to DONE is 2 cycles.
- The requester samples DONEx at t3 and must drop REQx before t4 unless it is issuing a new request.
- Simultaneous RESET and REQ: RESET wins and no grant is made.

## Configuration
- **COMP_TWO_OVF_EN defined:**
  - OVF port exists.
  - In CAPTURE, OVF is set to (OPR == 1 followed by WIDTH-1 zeros). It is updated together with DOUT and held until the next capture.
- **Not defined:** the OVF port and its logic are absent, and all other behaviour is identical.

## Test plan
- Assert RESET for 3 cycles mid-stream, then release → all outputs 0, BUSY=0, state IDLE.
- REQ0=1, DIN0=8'h07 sampled at t0 → DONE0=1 only between t2 and t3, DOUT=8'hF9, GNT0 high from t0 to t3, DONE1 stays 0.
- After reset, REQ0 and REQ1 rise together with DIN0=8'h01, DIN1=8'h02 →
  - DONE0 with DOUT=8'hFF first.
  - DONE1 with DOUT=8'hFE exactly 4 cycles later.
  - GNT0 and GNT1 are never high together.
- REQ0 and REQ1 held high continuously with constant operands → grants alternate 0,1,0,1; every DONE is exactly 4 cycles after the previous one.
- REQ1, DIN1=8'h05; pulse RESET during CAPTURE → no DONE1, DOUT=0; after release with REQ1 still high, DONE1 arrives with DOUT=8'hFB.
- COMP_TWO_OVF_EN: DIN0=8'h80 → DOUT=8'h80, OVF=1. Then DIN0=8'h00 → DOUT=8'h00, OVF=0.
